// File: rtl/seg14_scroll_scanner.sv
// Multiplexed 14-segment display scanner with a writable message buffer.
// Steps one-hot digit selects at a prescaled rate and can scroll the message
// one character every SCROLL_DIV completed frames.
module seg14_scroll_scanner #(
    parameter int N_DIGITS       = 12,
    parameter int MSG_LEN        = 16,
    parameter int SCAN_DIV       = 1,
    parameter int SCROLL_DIV     = 64,
    parameter bit SEL_ACTIVE_LOW = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_en,
    input  logic [$clog2(MSG_LEN)-1:0]     wr_addr,
    input  logic [13:0]                    wr_data,
    input  logic [$clog2(MSG_LEN+1)-1:0]   msg_len,
    input  logic                           scroll_en,
    input  logic                           blank,
    output logic [N_DIGITS-1:0]            sel,
    output logic [13:0]                    segm,
    output logic                           frame_done
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int LW = $clog2(MSG_LEN + 1);
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    localparam logic [DW-1:0]       DIGIT_LAST = DW'(N_DIGITS - 1);
    localparam logic [PW-1:0]       PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0]       FCNT_LAST  = FW'(SCROLL_DIV - 1);
    localparam logic [LW-1:0]       LEN_MAX    = LW'(MSG_LEN);
    localparam logic [N_DIGITS-1:0] SEL_IDLE   = {N_DIGITS{SEL_ACTIVE_LOW}};

    logic [13:0]         msg_buf [MSG_LEN];
    logic [PW-1:0]       presc;
    logic                tick;
    logic [DW-1:0]       digit;       // also the character position within the frame
    logic [AW-1:0]       ptr;
    logic [AW-1:0]       offset;
    logic [FW-1:0]       frame_cnt;
    logic [LW-1:0]       len_l;
    logic                scroll_l;    // scroll mode of the frame being shown

    logic [LW-1:0]       len_in;
    logic [N_DIGITS-1:0] sel_next;
    logic [13:0]         seg_next;
    logic [AW-1:0]       offset_adv;
    logic [AW-1:0]       offset_end;
    logic [FW-1:0]       fcnt_end;

    // Step an index through 0..len-1; a zero length pins it at 0.
    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] v, input logic [LW-1:0] len);
        if (int'(v) + 1 >= int'(len)) return '0;
        return v + 1'b1;
    endfunction

    assign tick = (presc == PRESC_LAST);

    // Display value for the digit about to be shown, plus clamped length input.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        len_in   = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
        sel_next = blank ? '0 : (N_DIGITS'(1) << digit);
        if (SEL_ACTIVE_LOW) sel_next = ~sel_next;
        seg_next = msg_buf[ptr];
        if (blank || (len_l == '0) || (!scroll_l && (int'(digit) >= int'(len_l))))
            seg_next = '0;
    end

    // Offset and scroll frame count to adopt at the end of the current frame.
    always_comb begin
        offset_adv = offset;
        fcnt_end   = '0;
        if (scroll_en && scroll_l) begin
            if (frame_cnt == FCNT_LAST) offset_adv = wrap_inc(offset, len_l);
            else                        fcnt_end   = frame_cnt + 1'b1;
        end else if (!scroll_en) begin
            offset_adv = '0;
        end
        offset_end = (int'(offset_adv) >= int'(len_in)) ? '0 : offset_adv;
    end

    // Message buffer: cleared on reset, written one entry per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the buffer is reset explicitly because it must read back as blank after reset.
        if (!rst_n) begin
            for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= '0;
        end else if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
            // Addresses past MSG_LEN only exist when MSG_LEN is not a power of two.
            msg_buf[wr_addr] <= wr_data;
        end
    end

    // Scan state: prescaler, digit/pointer stepping, frame-end bookkeeping, output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignment so all registers sample pre-edge values.
        if (!rst_n) begin
            presc      <= '0;
            digit      <= '0;
            ptr        <= '0;
            offset     <= '0;
            frame_cnt  <= '0;
            len_l      <= '0;
            scroll_l   <= 1'b0;
            sel        <= SEL_IDLE;
            segm       <= '0;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            frame_done <= 1'b0;
            if (tick) begin
                sel  <= sel_next;
                segm <= seg_next;
                if (digit == DIGIT_LAST) begin
                    digit      <= '0;
                    frame_done <= 1'b1;
                    len_l      <= len_in;
                    scroll_l   <= scroll_en;
                    offset     <= offset_end;
                    ptr        <= offset_end;
                    frame_cnt  <= fcnt_end;
                end else begin
                    digit <= digit + 1'b1;
                    ptr   <= wrap_inc(ptr, len_l);
                end
            end
        end
    end

endmodule

// File: tb/tb_seg14_scroll_scanner.sv
// Directed bench for seg14_scroll_scanner: expected per-digit display values are
// queued ahead of each frame and popped as each digit slot is observed.
module tb_seg14_scroll_scanner;

    localparam int N_DIGITS   = 4;
    localparam int MSG_LEN    = 8;
    localparam int SCAN_DIV   = 2;
    localparam int SCROLL_DIV = 1;

    typedef struct {
        string       tag;
        logic [3:0]  sel;
        logic [13:0] segm;
        logic        fd;
    } exp_t;

    exp_t exp_q[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [13:0] wr_data;
    logic [3:0]  msg_len;
    logic        scroll_en;
    logic        blank;
    logic [3:0]  sel, sel_b;
    logic [13:0] segm, segm_b;
    logic        frame_done, frame_done_b;

    int n_tests = 0;
    int n_fail  = 0;

    seg14_scroll_scanner #(
        .N_DIGITS(N_DIGITS), .MSG_LEN(MSG_LEN), .SCAN_DIV(SCAN_DIV),
        .SCROLL_DIV(SCROLL_DIV), .SEL_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .scroll_en(scroll_en), .blank(blank),
        .sel(sel), .segm(segm), .frame_done(frame_done)
    );

    seg14_scroll_scanner #(
        .N_DIGITS(N_DIGITS), .MSG_LEN(MSG_LEN), .SCAN_DIV(SCAN_DIV),
        .SCROLL_DIV(SCROLL_DIV), .SEL_ACTIVE_LOW(1'b1)
    ) dut_low (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .msg_len(msg_len), .scroll_en(scroll_en), .blank(blank),
        .sel(sel_b), .segm(segm_b), .frame_done(frame_done_b)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Queue one frame: four digits in order, frame_done on the last one.
    task automatic expect_frame(input string tag, input bit dark,
                                input logic [13:0] s0, input logic [13:0] s1,
                                input logic [13:0] s2, input logic [13:0] s3);
        logic [13:0] s [4];
        exp_t e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            e.tag  = $sformatf("%s.d%0d", tag, i);
            e.sel  = dark ? 4'b0000 : 4'(1 << i);
            e.segm = s[i];
            e.fd   = (i == 3);
            exp_q.push_back(e);
        end
    endtask

    task automatic write_entry(input logic [2:0] a, input logic [13:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    // One digit slot: the tick edge, then two sampled cycles (value + hold).
    task automatic run_slot();
        exp_t       e;
        logic [3:0] sel_low;
        @(posedge clk);
        @(negedge clk);
        wr_en = 1'b0;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: observed empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        sel_low = ~e.sel;
        check({e.tag, ".sel"},    sel,          e.sel);
        check({e.tag, ".sel_b"},  sel_b,        sel_low);
        check({e.tag, ".segm"},   segm,         e.segm);
        check({e.tag, ".segm_b"}, segm_b,       e.segm);
        check({e.tag, ".fd"},     frame_done,   e.fd);
        check({e.tag, ".fd_b"},   frame_done_b, e.fd);
        @(posedge clk);
        @(negedge clk);
        check({e.tag, ".sel_hold"},  sel,        e.sel);
        check({e.tag, ".segm_hold"}, segm,       e.segm);
        check({e.tag, ".fd_low"},    frame_done, 1'b0);
    endtask

    task automatic run_frame();
        repeat (4) run_slot();
    endtask

    initial begin
        rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        msg_len = '0; scroll_en = 1'b0; blank = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.sel",   sel,        4'b0000);
        check("rst.sel_b", sel_b,      4'b1111);
        check("rst.segm",  segm,       14'h0);
        check("rst.fd",    frame_done, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel.sel_idle",   sel,   4'b0000);
        check("rel.sel_b_idle", sel_b, 4'b1111);

        // First frame is dark (length latched as 0); load the message meanwhile.
        msg_len = 4'd3;
        expect_frame("f0", 1'b0, 14'h0, 14'h0, 14'h0, 14'h0);
        write_entry(3'd0, 14'h3AC0); run_slot();
        write_entry(3'd1, 14'h1F00); run_slot();
        write_entry(3'd2, 14'h33C4); run_slot();
        run_slot();

        // Static message, trailing digit dark.
        expect_frame("static", 1'b0, 14'h3AC0, 14'h1F00, 14'h33C4, 14'h0000);
        run_frame();

        // Scroll enabled mid-frame: this frame stays static.
        expect_frame("static2", 1'b0, 14'h3AC0, 14'h1F00, 14'h33C4, 14'h0000);
        run_slot();
        scroll_en = 1'b1;
        repeat (3) run_slot();

        // Scrolling frames, offset 0,1,2 then wrap to 0.
        expect_frame("scr0", 1'b0, 14'h3AC0, 14'h1F00, 14'h33C4, 14'h3AC0);
        expect_frame("scr1", 1'b0, 14'h1F00, 14'h33C4, 14'h3AC0, 14'h1F00);
        expect_frame("scr2", 1'b0, 14'h33C4, 14'h3AC0, 14'h1F00, 14'h33C4);
        expect_frame("scr3", 1'b0, 14'h3AC0, 14'h1F00, 14'h33C4, 14'h3AC0);
        repeat (4) run_frame();

        // Blank frame: dark, frame_done still pulses, offset keeps advancing.
        blank = 1'b1;
        expect_frame("blank", 1'b1, 14'h0, 14'h0, 14'h0, 14'h0);
        run_frame();
        blank = 1'b0;
        scroll_en = 1'b0;
        expect_frame("unblank", 1'b0, 14'h33C4, 14'h3AC0, 14'h1F00, 14'h33C4);
        run_frame();

        // Scroll off: offset back to 0; then zero length.
        msg_len = 4'd0;
        expect_frame("static3", 1'b0, 14'h3AC0, 14'h1F00, 14'h33C4, 14'h0000);
        run_frame();
        msg_len = 4'd9;
        expect_frame("len0", 1'b0, 14'h0, 14'h0, 14'h0, 14'h0);
        write_entry(3'd3, 14'h2A55);
        run_frame();

        // Length 9 clamps to 8: all four positions shown; write the displayed entry.
        expect_frame("len8", 1'b0, 14'h3AC0, 14'h1F00, 14'h33C4, 14'h2A55);
        run_slot();
        write_entry(3'd1, 14'h0155);
        repeat (3) run_slot();
        expect_frame("newval", 1'b0, 14'h3AC0, 14'h0155, 14'h33C4, 14'h2A55);
        run_frame();

        // Reset in the middle of a digit slot.
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst.sel",   sel,        4'b0000);
        check("midrst.sel_b", sel_b,      4'b1111);
        check("midrst.segm",  segm,       14'h0);
        check("midrst.fd",    frame_done, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        msg_len = 4'd3;
        @(posedge clk);
        @(negedge clk);
        check("rel2.sel_idle",   sel,   4'b0000);
        check("rel2.sel_b_idle", sel_b, 4'b1111);
        expect_frame("post_rst", 1'b0, 14'h0, 14'h0, 14'h0, 14'h0);
        expect_frame("buf_clr",  1'b0, 14'h0, 14'h0, 14'h0, 14'h0);
        repeat (2) run_frame();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
